mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the core's instruction-fetch port and data port, so the pipelined core can run on a unified RAM.
- Fixed priority to the data port, because that request comes from the later pipeline stage.
- A starvation guard bounds fetch stalls.
- A watchdog converts a hung memory access into an error response so the pipeline never deadlocks.

Parameters:
- MAX_DSTREAK, 4: maximum consecutive data grants while a fetch is pending; the next arbitration then goes to fetch.
- TIMEOUT, 64: cycles in a BUSY state without m_valid before the access is aborted.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- i_req  in  1  fetch request, held high until i_valid
- i_addr  in  32  fetch address, word aligned
- i_rdata  out  32  fetch data, valid with i_valid
- i_valid  out  1  one-cycle fetch response pulse
- d_req  in  1  data request, held high until d_valid
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_we  in  1  1 = store, 0 = load
- d_rdata  out  32  load data, valid with d_valid
- d_valid  out  1  one-cycle data response pulse
- m_req  out  1  memory access in progress
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_we  out  1  memory write enable
- m_rdata  in  32  memory read data
- m_valid  in  1  memory completion pulse
- err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset is synchronous on clk when reset_n=0:
  - state=IDLE; streak=0; tcnt=0; err_timeout=0.
  - Latched addr/wdata/we = 0.
  - m_req=0, m_we=0, i_valid=0, d_valid=0, and all data outputs read 0.
- Reset mid-access abandons the access. A stale m_valid arriving after reset is ignored, because it lands in IDLE.
- State machine: IDLE, BUSY_I, BUSY_D.
- In IDLE, arbitration is evaluated each cycle:
  - d_req=1 and (i_req=0 or streak<MAX_DSTREAK): latch d_addr/d_wdata/d_we and go to BUSY_D. If i_req=1, streak<=streak+1; otherwise streak<=0.
  - else if i_req=1: latch i_addr, we=0, wdata=0; go to BUSY_I; streak<=0.
  - otherwise stay in IDLE.
- Outputs in BUSY states:
  - m_req=1; m_addr/m_wdata/m_we come from the latched registers (registered outputs, stable for the whole access).
  - In IDLE, m_req=0 and m_we=0.
- Completion:
  - BUSY_X with m_valid=1: X_valid=1 combinationally in that cycle and X_rdata=m_rdata; next state IDLE; tcnt<=0.
  - The non-selected port's valid stays 0. m_valid in IDLE is ignored.
- Latency:
  - Request sampled in IDLE at cycle 0, m_req high at cycle 1.
  - With zero-wait memory (m_valid in the first BUSY cycle), the response arrives at cycle 1.
  - Back-to-back accesses: minimum 2 cycles per access, since IDLE always costs one cycle.
- Requester rule: a requester drops req (or presents a new request) on the clock edge after its valid pulse. The arbiter samples only in IDLE, so a held-over req is treated as a new request.
- Watchdog:
  - tcnt increments every BUSY cycle without m_valid.
  - When tcnt==TIMEOUT-1 and m_valid=0, the waiting port gets its valid pulse with rdata=32'h0; err_timeout<=1 (sticky until reset); state returns to IDLE.
- Simultaneous events: m_valid on the same cycle as the timeout boundary counts as a normal completion, and no error is raised.
- Address requests are not checked here (alignment is the core's concern). Request inputs are don't-care while in BUSY states.

Test Plan:
- Reset, then i_req=1, i_addr=0x100, memory responds with 0xDEADBEEF one cycle after m_req -> m_req high cycle 1, m_addr=0x100, m_we=0; i_valid pulse cycle 2 with i_rdata=0xDEADBEEF; d_valid never set.
- i_req and d_req both high in cycle 0, d_we=1, d_addr=0x2000, d_wdata=0x12345678 -> data granted first (m_we=1, m_wdata=0x12345678); fetch granted only after d_valid.
- d_req held continuously with new accesses and i_req held, MAX_DSTREAK=4 -> exactly 4 data grants, then 1 fetch grant, then data again; streak resets to 0.
- Grant d, memory never returns m_valid, TIMEOUT=64 -> d_valid pulses on the 64th BUSY cycle with d_rdata=0; err_timeout=1 and stays 1 across later successful accesses until reset.
- reset_n=0 during BUSY_I, then m_valid arrives 2 cycles after reset release -> no i_valid pulse; m_req=0; err_timeout=0; next request arbitrated normally.
- m_valid arrives exactly on cycle TIMEOUT-1 -> normal response with m_rdata; err_timeout stays 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch port, data port, memory port and watchdog flag of
// mem_port_arbiter. Signal names match the original flat ports.
//   fetch : i_req, i_addr -> i_rdata, i_valid
//   data  : d_req, d_addr, d_wdata, d_we -> d_rdata, d_valid
//   memory: m_req, m_addr, m_wdata, m_we -> m_rdata, m_valid
//   status: err_timeout (sticky watchdog flag)
// Modports:
//   slave  - the arbiter's view
//   master - the view of the surrounding core and memory
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;

  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_we;
  logic [31:0] d_rdata;
  logic        d_valid;

  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic [31:0] m_rdata;
  logic        m_valid;

  logic        err_timeout;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wdata, d_we, m_rdata, m_valid,
    output i_rdata, i_valid, d_rdata, d_valid, m_req, m_addr, m_wdata, m_we,
           err_timeout
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_wdata, d_we, m_rdata, m_valid,
    input  i_rdata, i_valid, d_rdata, d_valid, m_req, m_addr, m_wdata, m_we,
           err_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, variable-latency memory between the core's
// instruction-fetch port and data port. The data port has fixed priority,
// limited by a starvation guard: after MAX_DSTREAK consecutive data grants
// with a fetch pending, the next arbitration goes to fetch. A watchdog
// aborts an access that sees no m_valid for TIMEOUT BUSY cycles, returns
// rdata=0 to the waiting port and sets the sticky err_timeout flag.
// Ports:
//   clk      - clock
//   reset_n  - synchronous active-low reset
//   bus      - mem_port_arbiter_if.slave (fetch, data, memory, err_timeout)
// Parameters:
//   MAX_DSTREAK - max consecutive data grants while a fetch is pending
//   TIMEOUT     - BUSY cycles without m_valid before abort
//   CNT_W       - watchdog counter width, 2**CNT_W > TIMEOUT
module mem_port_arbiter #(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;

  localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);

  logic [1:0]       r_state;
  logic [SW-1:0]    r_streak;
  logic [CNT_W-1:0] r_tcnt;
  logic             r_err;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_we;

  logic w_busy;
  logic w_timeout;
  logic w_done;
  logic w_grant_d;

  assign w_busy    = (r_state != S_IDLE);
  // A real completion on the boundary cycle wins over the watchdog.
  assign w_timeout = w_busy && !bus.m_valid && (r_tcnt == CNT_W'(TIMEOUT - 1));
  assign w_done    = w_busy && (bus.m_valid || w_timeout);
  assign w_grant_d = bus.d_req && (!bus.i_req || (r_streak < SW'(MAX_DSTREAK)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_streak <= '0;
      r_tcnt   <= '0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tcnt <= '0;
          if (w_grant_d) begin
            r_addr   <= bus.d_addr;
            r_wdata  <= bus.d_wdata;
            r_we     <= bus.d_we;
            r_state  <= S_BUSY_D;
            // Streak only grows while a fetch is actually being held off.
            r_streak <= bus.i_req ? (r_streak + SW'(1)) : '0;
          end else if (bus.i_req) begin
            r_addr   <= bus.i_addr;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_state  <= S_BUSY_I;
            r_streak <= '0;
          end
        end
        default: begin
          if (w_done) begin
            r_state <= S_IDLE;
            r_tcnt  <= '0;
            if (w_timeout) r_err <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.m_req       = w_busy;
  assign bus.m_addr      = r_addr;
  assign bus.m_wdata     = r_wdata;
  assign bus.m_we        = w_busy && r_we;
  assign bus.i_valid     = (r_state == S_BUSY_I) && w_done;
  assign bus.d_valid     = (r_state == S_BUSY_D) && w_done;
  // rdata is forced to zero on a watchdog abort (m_valid low).
  assign bus.i_rdata     = ((r_state == S_BUSY_I) && bus.m_valid) ? bus.m_rdata : '0;
  assign bus.d_rdata     = ((r_state == S_BUSY_D) && bus.m_valid) ? bus.m_rdata : '0;
  assign bus.err_timeout = r_err;

endmodule
